// File: rtl/loader_pkg.sv
// Shared types and defaults for the UART instruction-memory loader.
// Frame/receiver state encodings live here so the bench and RTL agree on names.
package loader_pkg;

  localparam int         CLK_DIV_DEF = 868;   // 100 MHz / 115200 baud
  localparam logic [7:0] HDR_DEF     = 8'hA5;

  typedef enum logic [1:0] {S_IDLE, S_CNT, S_DATA, S_CHK} frameStateT;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rxStateT;

  // A count byte of zero encodes a full 256-word image.
  function automatic logic [8:0] wordCount(input logic [7:0] n);
    return (n == 8'd0) ? 9'd256 : {1'b0, n};
  endfunction

endpackage

// File: rtl/im_loader_if.sv
// Instruction-memory write port driven by the loader, consumed by the IM.
interface im_loader_if;
  logic        ImWe;
  logic [7:0]  ImWAdr;
  logic [31:0] ImWData;

  modport master (output ImWe, output ImWAdr, output ImWData);
  modport slave  (input  ImWe, input  ImWAdr, input  ImWData);
endinterface

// File: rtl/im_loader_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, one-cycle
// Valid on a good stop bit and one-cycle FrameErr on a low stop bit.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Rx,
  output logic [7:0] Data,
  output logic       Valid,
  output logic       FrameErr
);

  localparam int CW = $clog2(CLK_DIV) + 1;

  logic          rxMeta, rxSync, rxPrev;
  rxStateT       state;
  logic [CW-1:0] tick;
  logic [2:0]    bitIdx;
  logic [7:0]    shReg;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      // Sync chain parks at the idle-high level so no false start follows reset.
      rxMeta   <= 1'b1;
      rxSync   <= 1'b1;
      rxPrev   <= 1'b1;
      state    <= RX_IDLE;
      tick     <= '0;
      bitIdx   <= '0;
      shReg    <= '0;
      Data     <= '0;
      Valid    <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      rxMeta   <= Rx;
      rxSync   <= rxMeta;
      rxPrev   <= rxSync;
      Valid    <= 1'b0;
      FrameErr <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rxPrev && !rxSync) begin
            state <= RX_START;
            tick  <= CW'(CLK_DIV / 2 - 1);
          end
        end
        RX_START: begin
          if (tick == '0) begin
            if (rxSync) begin
              state <= RX_IDLE;          // glitch, not a real start bit
            end else begin
              state  <= RX_BITS;
              tick   <= CW'(CLK_DIV - 1);
              bitIdx <= '0;
            end
          end else begin
            tick <= tick - CW'(1);
          end
        end
        RX_BITS: begin
          if (tick == '0) begin
            shReg  <= {rxSync, shReg[7:1]};
            tick   <= CW'(CLK_DIV - 1);
            bitIdx <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) state <= RX_STOP;
          end else begin
            tick <= tick - CW'(1);
          end
        end
        RX_STOP: begin
          if (tick == '0) begin
            state <= RX_IDLE;
            if (rxSync) begin
              Data  <= shReg;
              Valid <= 1'b1;
            end else begin
              FrameErr <= 1'b1;
            end
          end else begin
            tick <= tick - CW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/im_loader.sv
// UART boot loader: receives HDR, count, big-endian words and an XOR checksum,
// writes each word into instruction memory and holds the CPU while loading.
module im_loader
  import loader_pkg::*;
#(
  parameter int         CLK_DIV = CLK_DIV_DEF,
  parameter logic [7:0] HDR     = HDR_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Rx,
  im_loader_if.master imBus,
  output logic        CpuHold,
  output logic        Done,
  output logic        Err
);

  logic [7:0] rxData;
  logic       rxValid, rxErr;

  uart_rx #(.CLK_DIV(CLK_DIV)) uRx (
    .Clk      (Clk),
    .Reset    (Reset),
    .Rx       (Rx),
    .Data     (rxData),
    .Valid    (rxValid),
    .FrameErr (rxErr)
  );

  frameStateT state;
  logic [1:0] byteIdx;
  logic [8:0] wordsLeft;
  logic [7:0] csum;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state         <= S_IDLE;
      byteIdx       <= '0;
      wordsLeft     <= '0;
      csum          <= '0;
      imBus.ImWe    <= 1'b0;
      imBus.ImWAdr  <= '0;
      imBus.ImWData <= '0;
      CpuHold       <= 1'b0;
      Done          <= 1'b0;
      Err           <= 1'b0;
    end else begin
      imBus.ImWe <= 1'b0;

      // The write cycle itself stays in DATA; the address advances and the
      // frame moves to CHK only once the strobe has been presented.
      if (imBus.ImWe) begin
        imBus.ImWAdr <= imBus.ImWAdr + 8'd1;
        wordsLeft    <= wordsLeft - 9'd1;
        if (wordsLeft == 9'd1) state <= S_CHK;
      end

      if (rxErr && state != S_IDLE) begin
        state   <= S_IDLE;
        byteIdx <= '0;
        CpuHold <= 1'b0;
        Done    <= 1'b0;
        Err     <= 1'b1;
      end else if (rxValid) begin
        case (state)
          S_IDLE: begin
            if (rxData == HDR) begin
              state   <= S_CNT;
              CpuHold <= 1'b1;
              Done    <= 1'b0;
              Err     <= 1'b0;
            end
          end
          S_CNT: begin
            wordsLeft    <= wordCount(rxData);
            imBus.ImWAdr <= '0;
            csum         <= '0;
            byteIdx      <= '0;
            state        <= S_DATA;
          end
          S_DATA: begin
            // HDR is ordinary payload here; first byte lands in [31:24].
            imBus.ImWData <= {imBus.ImWData[23:0], rxData};
            csum          <= csum ^ rxData;
            byteIdx       <= byteIdx + 2'd1;
            if (byteIdx == 2'd3) imBus.ImWe <= 1'b1;
          end
          S_CHK: begin
            if (rxData == csum) Done <= 1'b1;
            else                Err  <= 1'b1;
            CpuHold <= 1'b0;
            state   <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Randomised frame-level bench for im_loader: a frame model predicts the IM
// writes and final flags; a per-cycle monitor checks every write strobe.
module tb_im_loader;

  localparam int         DIV  = 4;
  localparam logic [7:0] HDRB = 8'hA5;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic rx = 1'b1;
  logic cpuHold, done, err;

  im_loader_if bus();

  im_loader #(.CLK_DIV(DIV), .HDR(HDRB)) dut (
    .Clk     (clk),
    .Reset   (rstN),
    .Rx      (rx),
    .imBus   (bus),
    .CpuHold (cpuHold),
    .Done    (done),
    .Err     (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  adr;
    logic [31:0] data;
  } wrT;

  wrT          expQ[$];
  wrT          e;
  int          total = 0;
  int          bad = 0;
  int          nWrites = 0;
  int          w0;
  logic [7:0]  lastAdr = '0;
  logic [31:0] lastData = '0;
  logic        prevWe = 1'b0;
  logic [31:0] wordsBuf [256];
  int          rn, rCs, rErr;
  logic [7:0]  stray;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the next expected word, last one cycle.
  always @(negedge clk) begin
    if (rstN) begin
      if (bus.ImWe) begin
        nWrites++;
        lastAdr  = bus.ImWAdr;
        lastData = bus.ImWData;
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected write: adr %h data %h", bus.ImWAdr, bus.ImWData);
        end else begin
          e = expQ.pop_front();
          check("write adr", {24'd0, bus.ImWAdr}, {24'd0, e.adr});
          check("write data", bus.ImWData, e.data);
        end
        check("we single cycle", {31'd0, prevWe}, 32'd0);
      end
      check("done/err exclusive", {31'd0, done & err}, 32'd0);
      prevWe = bus.ImWe;
    end else begin
      prevWe = 1'b0;
    end
  end

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stopBit;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // Sends HDR, n, the first n words of wordsBuf and a checksum. csumOvr<0 sends
  // the true XOR; errAt>=0 forces a low stop bit on that data byte index.
  task automatic runFrame(input int n, input int csumOvr, input int errAt);
    int         nw, k;
    logic [7:0] cs, b, sent;
    logic       aborted;
    nw      = (n == 0) ? 256 : n;
    k       = 0;
    cs      = '0;
    sent    = '0;
    aborted = 1'b0;
    sendByte(HDRB, 1'b1);
    sendByte(n[7:0], 1'b1);
    repeat (3) @(negedge clk);
    check("hold in frame", {31'd0, cpuHold}, 32'd1);
    check("done cleared", {31'd0, done}, 32'd0);
    check("err cleared", {31'd0, err}, 32'd0);
    for (int w = 0; w < nw && !aborted; w++) begin
      for (int j = 3; j >= 0 && !aborted; j--) begin
        b = wordsBuf[w][8*j +: 8];
        if (k == errAt) begin
          sendByte(b, 1'b0);
          aborted = 1'b1;
        end else begin
          cs ^= b;
          if (j == 0) expQ.push_back(wrT'{adr: w[7:0], data: wordsBuf[w]});
          sendByte(b, 1'b1);
        end
        k++;
      end
    end
    if (!aborted) begin
      sent = (csumOvr < 0) ? cs : csumOvr[7:0];
      sendByte(sent, 1'b1);
    end
    repeat (8) @(negedge clk);
    check("frame done", {31'd0, done}, {31'd0, !aborted && sent == cs});
    check("frame err", {31'd0, err}, {31'd0, aborted || sent != cs});
    check("hold released", {31'd0, cpuHold}, 32'd0);
    check("writes drained", expQ.size(), 32'd0);
    expQ.delete();
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " ImWe"}, {31'd0, bus.ImWe}, 32'd0);
    check({tag, " ImWAdr"}, {24'd0, bus.ImWAdr}, 32'd0);
    check({tag, " ImWData"}, bus.ImWData, 32'd0);
    check({tag, " CpuHold"}, {31'd0, cpuHold}, 32'd0);
    check({tag, " Done"}, {31'd0, done}, 32'd0);
    check({tag, " Err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;
    repeat (4) @(negedge clk);

    // Single word, correct checksum 20^08^00^05 = 2D.
    wordsBuf[0] = 32'h20080005;
    w0 = nWrites;
    runFrame(1, 8'h2D, -1);
    check("A write count", nWrites - w0, 32'd1);
    check("A adr", {24'd0, lastAdr}, 32'h00);
    check("A data", lastData, 32'h20080005);
    check("A done", {31'd0, done}, 32'd1);

    // Two words, checksum 8C^01^AC^02^04 = 27.
    wordsBuf[0] = 32'h8C010000;
    wordsBuf[1] = 32'hAC020004;
    w0 = nWrites;
    runFrame(2, 8'h27, -1);
    check("B write count", nWrites - w0, 32'd2);
    check("B last adr", {24'd0, lastAdr}, 32'h01);
    check("B last data", lastData, 32'hAC020004);
    check("B done", {31'd0, done}, 32'd1);

    // Bad checksum still writes the word.
    wordsBuf[0] = 32'h20080005;
    w0 = nWrites;
    runFrame(1, 8'h24, -1);
    check("C write count", nWrites - w0, 32'd1);
    check("C err", {31'd0, err}, 32'd1);
    check("C done", {31'd0, done}, 32'd0);

    // Framing error on the 2nd data byte, then a good frame recovers.
    w0 = nWrites;
    runFrame(1, -1, 1);
    check("D write count", nWrites - w0, 32'd0);
    check("D err", {31'd0, err}, 32'd1);
    runFrame(1, -1, -1);
    check("D recover done", {31'd0, done}, 32'd1);
    check("D recover err", {31'd0, err}, 32'd0);

    // Full 256-word image via count byte 0.
    for (int w = 0; w < 256; w++) wordsBuf[w] = $urandom;
    w0 = nWrites;
    runFrame(0, -1, -1);
    check("E write count", nWrites - w0, 32'd256);
    check("E last adr", {24'd0, lastAdr}, 32'hFF);
    check("E done", {31'd0, done}, 32'd1);

    // Reset pulse after the 3rd data byte aborts the frame.
    for (int w = 0; w < 4; w++) wordsBuf[w] = $urandom;
    w0 = nWrites;
    sendByte(HDRB, 1'b1);
    sendByte(8'h02, 1'b1);
    for (int j = 3; j >= 1; j--) sendByte(wordsBuf[0][8*j +: 8], 1'b1);
    rstN = 1'b0;
    @(negedge clk);
    checkAllZero("mid reset");
    rstN = 1'b1;
    sendByte(8'h11, 1'b1);
    sendByte(8'h22, 1'b1);
    check("F no stray write", nWrites - w0, 32'd0);
    runFrame(2, -1, -1);
    check("F write count", nWrites - w0, 32'd2);

    // Random frames: HDR inside payload, bad checksums, framing errors, strays.
    for (int t = 0; t < 8; t++) begin
      rn = $urandom_range(1, 5);
      for (int w = 0; w < rn; w++) wordsBuf[w] = $urandom;
      if (t % 2 == 0) wordsBuf[0][31:24] = HDRB;
      rCs  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : -1;
      rErr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4 * rn - 1)) : -1;
      runFrame(rn, rCs, rErr);
      stray = 8'($urandom);
      if (stray == HDRB) stray = 8'h5A;
      sendByte(stray, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
